// File: rtl/host_seq.sv
// host_seq: host-side sequencer for a compute core.
// It streams operand bytes into the core data memory, pulses a start request,
// waits for a fresh rising edge of the core's done flag (bounded by a cycle
// budget), and then streams the result bytes back out over a valid/ready port.
module host_seq #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_N    = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_N     = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_wr_en,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wr_dat,
    input  logic [7:0] mem_rd_dat,
    output logic       req,
    input  logic       done,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       fin,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_RD   = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    localparam logic [7:0]  LOAD_BASE_B = 8'(LOAD_BASE);
    localparam logic [7:0]  RES_BASE_B  = 8'(RES_BASE);
    localparam logic [8:0]  LOAD_LAST   = 9'(LOAD_N - 1);
    localparam logic [8:0]  RES_LAST    = 9'(RES_N - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
    localparam bit          LOAD_EMPTY  = (LOAD_N == 0);
    localparam bit          RES_EMPTY   = (RES_N == 0);

    state_t      state_r;
    state_t      state_nx_s;
    logic [8:0]  idx_r;
    logic [15:0] tcnt_r;
    logic        done_q_r;
    logic        armed_r;
    logic [7:0]  out_data_r;
    logic        timeout_r;
    logic        fin_r;

    logic        idx_clr_s;
    logic        idx_inc_s;
    logic        tcnt_clr_s;
    logic        tcnt_inc_s;
    logic        to_set_s;
    logic        to_clr_s;
    logic        fin_set_s;
    logic        out_load_s;
    logic        complete_s;

    // A done level only completes the wait once done has been seen low since
    // the request, and only on its rising edge.
    assign complete_s = done & ~done_q_r & armed_r;

    // Next-state decode and per-state combinational outputs.
    always_comb begin
        state_nx_s = state_r;
        idx_clr_s  = 1'b0;
        idx_inc_s  = 1'b0;
        tcnt_clr_s = 1'b0;
        tcnt_inc_s = 1'b0;
        to_set_s   = 1'b0;
        to_clr_s   = 1'b0;
        fin_set_s  = 1'b0;
        out_load_s = 1'b0;
        in_ready   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = 8'd0;
        mem_wr_dat = 8'd0;
        req        = 1'b0;
        out_valid  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    idx_clr_s  = 1'b1;
                    to_clr_s   = 1'b1;
                    state_nx_s = LOAD_EMPTY ? S_REQ : S_LOAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: begin
                in_ready   = 1'b1;
                mem_wr_en  = in_valid;
                mem_addr   = LOAD_BASE_B + idx_r[7:0];
                mem_wr_dat = in_data;
                if (in_valid) begin
                    idx_inc_s = 1'b1;
                    if (idx_r == LOAD_LAST) begin
                        state_nx_s = S_REQ;
                    end else begin
                        state_nx_s = S_LOAD;
                    end
                end else begin
                    state_nx_s = S_LOAD;
                end
            end
            S_REQ: begin
                req        = 1'b1;
                tcnt_clr_s = 1'b1;
                state_nx_s = S_WAIT;
            end
            S_WAIT: begin
                if (complete_s) begin
                    idx_clr_s = 1'b1;
                    if (RES_EMPTY) begin
                        fin_set_s  = 1'b1;
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s = S_RD;
                    end
                end else if (tcnt_r == TO_LAST) begin
                    to_set_s   = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    tcnt_inc_s = 1'b1;
                    state_nx_s = S_WAIT;
                end
            end
            S_RD: begin
                mem_addr   = RES_BASE_B + idx_r[7:0];
                out_load_s = 1'b1;
                state_nx_s = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_r == RES_LAST) begin
                        fin_set_s  = 1'b1;
                        state_nx_s = S_IDLE;
                    end else begin
                        idx_inc_s  = 1'b1;
                        state_nx_s = S_RD;
                    end
                end else begin
                    state_nx_s = S_OUT;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register, counters, done edge tracking and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            idx_r      <= 9'd0;
            tcnt_r     <= 16'd0;
            done_q_r   <= 1'b0;
            armed_r    <= 1'b0;
            out_data_r <= 8'd0;
            timeout_r  <= 1'b0;
            fin_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (idx_clr_s) begin
                idx_r <= 9'd0;
            end else if (idx_inc_s) begin
                idx_r <= idx_r + 9'd1;
            end
            if (tcnt_clr_s) begin
                tcnt_r <= 16'd0;
            end else if (tcnt_inc_s) begin
                tcnt_r <= tcnt_r + 16'd1;
            end
            done_q_r <= (state_r == S_WAIT) ? done : 1'b0;
            if (state_r == S_REQ) begin
                armed_r <= ~done;
            end else if (state_r == S_WAIT) begin
                armed_r <= armed_r | ~done;
            end else begin
                armed_r <= 1'b0;
            end
            if (out_load_s) begin
                out_data_r <= mem_rd_dat;
            end
            if (to_clr_s) begin
                timeout_r <= 1'b0;
            end else if (to_set_s) begin
                timeout_r <= 1'b1;
            end
            fin_r <= fin_set_s;
        end
    end

    assign out_data = out_data_r;
    assign timeout  = timeout_r;
    assign fin      = fin_r;
    assign busy     = (state_r != S_IDLE);

endmodule

// File: tb/tb_host_seq.sv
// Testbench for host_seq: scoreboard queues filled by the stimulus, drained by
// negedge monitors. Instance a uses default parameters; instance b uses a
// wrapping load window, a short result set and a short timeout.
module tb_host_seq;

    logic       clk;
    logic       rst_n;
    int         total;
    int         bad;

    logic       start_a, in_valid_a, in_ready_a, mem_wr_en_a, req_a, done_a;
    logic       out_valid_a, out_ready_a, busy_a, fin_a, timeout_a;
    logic [7:0] in_data_a, mem_addr_a, mem_wr_dat_a, mem_rd_dat_a, out_data_a;

    logic       start_b, in_valid_b, in_ready_b, mem_wr_en_b, req_b, done_b;
    logic       out_valid_b, out_ready_b, busy_b, fin_b, timeout_b;
    logic [7:0] in_data_b, mem_addr_b, mem_wr_dat_b, mem_rd_dat_b, out_data_b;

    logic [15:0] wq_a[$];
    logic [15:0] wq_b[$];
    logic [7:0]  oq_a[$];
    int          fin_cnt_a;
    int          req_cnt_a;
    int          ov_cnt_b;

    // Core memory model: read data is a fixed function of the address.
    assign mem_rd_dat_a = mem_addr_a ^ 8'h5A;
    assign mem_rd_dat_b = mem_addr_b ^ 8'h5A;

    host_seq u_a (
        .clk(clk), .reset(rst_n), .start(start_a), .in_valid(in_valid_a),
        .in_data(in_data_a), .in_ready(in_ready_a), .mem_wr_en(mem_wr_en_a),
        .mem_addr(mem_addr_a), .mem_wr_dat(mem_wr_dat_a), .mem_rd_dat(mem_rd_dat_a),
        .req(req_a), .done(done_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ready(out_ready_a), .busy(busy_a), .fin(fin_a), .timeout(timeout_a)
    );

    host_seq #(.LOAD_BASE(250), .LOAD_N(10), .RES_BASE(64), .RES_N(2), .TIMEOUT(10)) u_b (
        .clk(clk), .reset(rst_n), .start(start_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .mem_wr_en(mem_wr_en_b),
        .mem_addr(mem_addr_b), .mem_wr_dat(mem_wr_dat_b), .mem_rd_dat(mem_rd_dat_b),
        .req(req_b), .done(done_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready_b), .busy(busy_b), .fin(fin_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for instance a: writes, output handshakes, pulse counters.
    always @(negedge clk) begin
        if (mem_wr_en_a) begin
            if (wq_a.size() == 0) begin
                check("a_unexpected_write", {mem_addr_a, mem_wr_dat_a}, 16'hFFFF);
            end else begin
                check("a_write", {mem_addr_a, mem_wr_dat_a}, wq_a.pop_front());
            end
        end
        if (in_ready_a && !in_valid_a) begin
            check("a_gap_no_write", mem_wr_en_a, 1'b0);
        end
        if (out_valid_a && out_ready_a) begin
            if (oq_a.size() == 0) begin
                check("a_unexpected_out", {24'd0, out_data_a}, 32'hFFFF);
            end else begin
                check("a_out", out_data_a, oq_a.pop_front());
            end
        end
        if (fin_a) fin_cnt_a++;
        if (req_a) req_cnt_a++;
    end

    // Monitor for instance b: writes and any result presentation.
    always @(negedge clk) begin
        if (mem_wr_en_b) begin
            if (wq_b.size() == 0) begin
                check("b_unexpected_write", {mem_addr_b, mem_wr_dat_b}, 16'hFFFF);
            end else begin
                check("b_write", {mem_addr_b, mem_wr_dat_b}, wq_b.pop_front());
            end
        end
        if (out_valid_b) ov_cnt_b++;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] d0;
        logic [7:0] wa;
        total = 0; bad = 0; fin_cnt_a = 0; req_cnt_a = 0; ov_cnt_b = 0;
        rst_n = 1'b0;
        start_a = 1'b0; in_valid_a = 1'b0; in_data_a = 8'd0; done_a = 1'b1; out_ready_a = 1'b0;
        start_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'd0; done_b = 1'b0; out_ready_b = 1'b1;
        #1;
        check("rst_busy", busy_a, 1'b0);
        check("rst_outs", {req_a, mem_wr_en_a, in_ready_a, out_valid_a, fin_a, timeout_a}, 6'd0);
        check("rst_data", {mem_addr_a, mem_wr_dat_a, out_data_a}, 24'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Load 64 bytes with gaps; done is a stale high level from before start.
        for (int i = 0; i < 64; i++) wq_a.push_back({8'(i), 8'(i)});
        for (int i = 0; i < 32; i++) oq_a.push_back(8'(64 + i) ^ 8'h5A);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        check("a_load_busy", busy_a, 1'b1);
        for (int i = 0; i < 64; i++) begin
            if (i % 5 == 2) begin
                in_valid_a = 1'b0;
                tick(1);
            end
            in_valid_a = 1'b1;
            in_data_a  = 8'(i);
            tick(1);
        end
        in_valid_a = 1'b0;
        n = 0;
        while (!req_a && n < 20) begin tick(1); n++; end
        check("a_req_seen", req_a, 1'b1);
        check("a_writes_drained", wq_a.size(), 32'd0);
        tick(6);
        check("a_stale_done_ignored", {busy_a, out_valid_a}, 2'b10);
        done_a = 1'b0;
        tick(3);
        check("a_wait_during_low", {busy_a, out_valid_a}, 2'b10);
        done_a = 1'b1;
        n = 0;
        while (!out_valid_a && n < 20) begin tick(1); n++; end
        check("a_out_valid_seen", out_valid_a, 1'b1);
        d0 = out_data_a;
        check("a_byte0", d0, 8'(64) ^ 8'h5A);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("a_hold_valid", out_valid_a, 1'b1);
            check("a_hold_data", out_data_a, d0);
        end
        out_ready_a = 1'b1;
        n = 0;
        while (!fin_a && n < 200) begin tick(1); n++; end
        check("a_fin_seen", fin_a, 1'b1);
        out_ready_a = 1'b0;
        tick(2);
        check("a_fin_once", fin_cnt_a, 32'd1);
        check("a_req_once", req_cnt_a, 32'd1);
        check("a_outs_drained", oq_a.size(), 32'd0);
        check("a_idle_after", busy_a, 1'b0);

        // Reset while the request is being issued.
        done_a = 1'b0;
        for (int i = 0; i < 64; i++) wq_a.push_back({8'(i), 8'(255 - i)});
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = 8'(255 - i);
            tick(1);
        end
        in_valid_a = 1'b0;
        check("a2_req_high", req_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("a2_rst_req_drop", req_a, 1'b0);
        check("a2_rst_idle", {busy_a, mem_wr_en_a}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        check("a2_no_fin", fin_cnt_a, 32'd1);
        check("a2_still_idle", busy_a, 1'b0);

        // Reset during load with a byte being offered.
        for (int i = 0; i < 5; i++) wq_a.push_back({8'(i), 8'(i + 16)});
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = 8'(i + 16);
            tick(1);
        end
        in_data_a = 8'd21;
        #1;
        check("a3_write_active", mem_wr_en_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("a3_rst_wr_drop", {mem_wr_en_a, in_ready_a, busy_a}, 3'b000);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("a3_writes", wq_a.size(), 32'd0);
        check("a3_no_fin", fin_cnt_a, 32'd1);

        // Instance b: wrapping load addresses, then timeout with done held low.
        for (int i = 0; i < 10; i++) begin
            wa = 8'd250 + 8'(i);
            wq_b.push_back({wa, 8'(i + 128)});
        end
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid_b = 1'b1;
            in_data_b  = 8'(i + 128);
            tick(1);
        end
        in_valid_b = 1'b0;
        n = 0;
        while (!req_b && n < 20) begin tick(1); n++; end
        check("b_req_seen", req_b, 1'b1);
        check("b_writes", wq_b.size(), 32'd0);
        tick(10);
        check("b_before_expiry", {busy_b, timeout_b}, 2'b10);
        tick(1);
        check("b_expired", {busy_b, timeout_b}, 2'b01);
        tick(3);
        check("b_timeout_sticky", timeout_b, 1'b1);
        check("b_no_out_valid", ov_cnt_b, 32'd0);
        check("b_no_fin", fin_b, 1'b0);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        check("b_restart_clears", {timeout_b, busy_b, in_ready_b}, 3'b011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
